// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory write-buffer responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  // Word index width for a full 32-bit byte address.
  localparam int unsigned IDX_W  = WORD_W - 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } drain_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store FIFO with a youngest-match lookup used for load forwarding.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  wb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output logic [clog2(Depth):0]  count_o,
  input  logic [IDX_W-1:0]       lookup_idx_i,
  output logic                   hit_o,
  output logic [WORD_W-1:0]      hit_data_o
);

  localparam int unsigned PtrW = clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t         mem_q [Depth];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop_i) begin
      head_d = head_q + 1'b1;
    end
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // Walk from oldest to youngest so the last valid match wins.
  always_comb begin
    logic [PtrW-1:0] slot;
    slot       = '0;
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      slot = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (mem_q[slot].idx == lookup_idx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[slot].data;
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// M-stage data memory: stores post into a write buffer that drains into a word RAM
// at a fixed cadence; loads are combinational and forward from pending stores.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned WB_DEPTH  = 4,
  parameter int unsigned DRAIN_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [WORD_W-1:0] ALUOutM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              WbEmpty
);

  localparam int unsigned AddrW = clog2(MEM_WORDS);
  localparam int unsigned CntW  = clog2(WB_DEPTH) + 1;
  localparam int unsigned DlyW  = (DRAIN_LAT > 1) ? clog2(DRAIN_LAT) : 1;
  localparam logic [DlyW-1:0] DlyReload = DlyW'(DRAIN_LAT - 1);
  localparam logic [CntW-1:0] FullCount = CntW'(WB_DEPTH);

  logic [WORD_W-1:0] ram_q [MEM_WORDS];

  drain_state_e      state_q, state_d;
  logic [DlyW-1:0]   dly_q, dly_d;

  logic [AddrW-1:0]  word_idx;
  logic [IDX_W-1:0]  entry_idx;
  wb_entry_t         push_entry;
  wb_entry_t         head_entry;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_next;
  logic              push;
  logic              pop;
  logic              hit;
  logic [WORD_W-1:0] hit_data;

  // Byte offset and address bits above the RAM size are don't-care by design.
  logic unused_bits;
  assign unused_bits = ^{ALUOutM[1:0], ALUOutM[WORD_W-1:AddrW+2],
                         head_entry.idx[IDX_W-1:AddrW]};

  assign word_idx   = ALUOutM[AddrW+1:2];
  assign entry_idx  = IDX_W'(word_idx);
  assign push_entry = '{idx: entry_idx, data: WriteDataM};

  assign pop     = (state_q == StDrain) && (dly_q == '0);
  assign StallM  = MemWriteM && (count == FullCount) && !pop;
  assign push    = MemWriteM && !StallM;
  assign WbEmpty = (count == '0);

  wbuf_fifo #(
    .Depth        (WB_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head_entry),
    .count_o      (count),
    .lookup_idx_i (entry_idx),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    unique case (state_q)
      StIdle: begin
        if (count != '0) begin
          state_d = StDrain;
          dly_d   = DlyReload;
        end
      end
      StDrain: begin
        if (dly_q == '0) begin
          if (count_next != '0) begin
            dly_d = DlyReload;
          end else begin
            state_d = StIdle;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dly_q   <= DlyReload;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  // Backing RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (pop) begin
      ram_q[head_entry.idx[AddrW-1:0]] <= head_entry.data;
    end
  end

  assign ReadDataM = hit ? hit_data : ram_q[word_idx];

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: vector table plus hand-traced burst and reset sequences.
module tb_dmem_wbuf;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        WbEmpty;

  int checks = 0;
  int errors = 0;

  dmem_wbuf #(
    .MEM_WORDS  (64),
    .WB_DEPTH   (4),
    .DRAIN_LAT  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .WbEmpty    (WbEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic        stall;
    logic        empty;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWriteM  = we;
    ALUOutM    = addr;
    WriteDataM = data;
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    drive(1'b0, 32'h0, 32'h0);
    while (!WbEmpty && n < budget) begin
      drive(1'b0, 32'h0, 32'h0);
      n++;
    end
    check("wait_empty", {31'd0, WbEmpty}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_stall [8];
    int   k;

    // we, addr, wdata, chk_rd, rd, stall, empty
    vecs[0]  = '{1'b1, 32'h20,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'h20,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h20,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h20,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'h40,  32'h1,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'h40,  32'h2,        1'b1, 32'h1,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h40,  32'h0,        1'b1, 32'h2,        1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h40,  32'h0,        1'b1, 32'h2,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h40,  32'h0,        1'b1, 32'h2,        1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h40,  32'h0,        1'b1, 32'h2,        1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h40,  32'h0,        1'b1, 32'h2,        1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'h4,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h204, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h7,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 32'h4,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 32'h20,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 32'h10,  32'hAAAA0000, 1'b1, 32'h12345678, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hAAAA0000, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hAAAA0000, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hAAAA0000, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hAAAA0000, 1'b0, 1'b1};

    reset      = 1'b1;
    MemWriteM  = 1'b0;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Preload RAM[4] through the buffer, then reset: RAM must keep it.
    drive(1'b1, 32'h10, 32'h12345678);
    wait_empty(20);
    drive(1'b0, 32'h10, 32'h0);
    reset = 1'b1;
    #1;
    check("rst_rd",    ReadDataM, 32'h12345678);
    check("rst_empty", {31'd0, WbEmpty}, 32'd1);
    check("rst_stall", {31'd0, StallM},  32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rd) begin
        check($sformatf("vec%0d_rd", i), ReadDataM, vecs[i].rd);
      end
      check($sformatf("vec%0d_stall", i), {31'd0, StallM},  {31'd0, vecs[i].stall});
      check($sformatf("vec%0d_empty", i), {31'd0, WbEmpty}, {31'd0, vecs[i].empty});
    end

    // Burst of 7 stores from idle: full+pop at t5 is accepted, t6 stalls, t7 accepted.
    exp_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    k = 0;
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, 32'h80 + 32'(4 * k), 32'h100 + 32'(k));
      check($sformatf("burst_t%0d_stall", t), {31'd0, StallM}, {31'd0, exp_stall[t]});
      if (!StallM) k++;
    end
    for (int t = 8; t <= 16; t++) begin
      drive(1'b0, 32'h0, 32'h0);
      check($sformatf("burst_t%0d_empty", t), {31'd0, WbEmpty}, {31'd0, (t == 16)});
    end
    for (int j = 0; j < 7; j++) begin
      drive(1'b0, 32'h80 + 32'(4 * j), 32'h0);
      check($sformatf("burst_ram%0d", j), ReadDataM, 32'h100 + 32'(j));
    end

    // Reset mid-drain: first store popped at t3, reset during t4.
    drive(1'b1, 32'hC4, 32'h11);
    drive(1'b1, 32'hC8, 32'h22);
    wait_empty(20);
    drive(1'b1, 32'hC0, 32'h300);
    drive(1'b1, 32'hC4, 32'h301);
    drive(1'b1, 32'hC8, 32'h302);
    drive(1'b0, 32'hC4, 32'h0);
    check("mid_fwd", ReadDataM, 32'h301);
    drive(1'b0, 32'h0, 32'h0);
    check("mid_empty_pre", {31'd0, WbEmpty}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_empty_rst", {31'd0, WbEmpty}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 32'hC0, 32'h0);
    check("mid_ram48", ReadDataM, 32'h300);
    drive(1'b0, 32'hC4, 32'h0);
    check("mid_ram49", ReadDataM, 32'h11);
    drive(1'b0, 32'hC8, 32'h0);
    check("mid_ram50", ReadDataM, 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
